// File: rtl/hs_unit_reset_sequencer_if.sv
// hs_unit_reset_sequencer_if: request/acknowledge and status bundle between the
// reset sequencer (master) and the reset domains it controls (slave).
interface hs_unit_reset_sequencer_if #(
    parameter int NUM_STAGES = 4
) ();
    localparam int EW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    logic                  soft_req;
    logic [NUM_STAGES-1:0] stage_ack;
    logic [NUM_STAGES-1:0] stage_resetn;
    logic                  seq_busy;
    logic                  seq_done;
    logic                  timeout_err;
    logic [EW-1:0]         err_stage;
    modport master (
        input  soft_req, stage_ack,
        output stage_resetn, seq_busy, seq_done, timeout_err, err_stage
    );
    modport slave (
        output soft_req, stage_ack,
        input  stage_resetn, seq_busy, seq_done, timeout_err, err_stage
    );
endinterface

// File: rtl/hs_unit_reset_sequencer.sv
// hs_unit_reset_sequencer: holds all domain resets, then releases them one at a
// time in index order, waiting for each domain's acknowledge with a timeout.
module hs_unit_reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int ACK_TIMEOUT = 256
) (
    input  logic clk,
    input  logic resetn,
    hs_unit_reset_sequencer_if.master bus
);
    localparam int EW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [EW-1:0] LAST = EW'(NUM_STAGES - 1);
    typedef enum logic [2:0] {HOLD, RELEASE, WAIT_ACK, DONE, ERROR} state_t;
    state_t        state;
    logic [15:0]   hold_cnt;
    logic [15:0]   ack_cnt;
    logic [EW-1:0] k;
    // A soft request restarts exactly like reset, including clearing the sticky error.
    always_ff @(posedge clk) begin
        if (!resetn || bus.soft_req) begin
            state            <= HOLD;
            hold_cnt         <= 16'(HOLD_CYCLES);
            ack_cnt          <= '0;
            k                <= '0;
            bus.stage_resetn <= '0;
            bus.seq_busy     <= 1'b1;
            bus.seq_done     <= 1'b0;
            bus.timeout_err  <= 1'b0;
            bus.err_stage    <= '0;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_cnt == 16'd0) state <= RELEASE;
                    else hold_cnt <= hold_cnt - 16'd1;
                end
                RELEASE: begin
                    bus.stage_resetn[k] <= 1'b1;
                    ack_cnt             <= 16'(ACK_TIMEOUT);
                    state               <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (bus.stage_ack[k]) begin
                        if (k == LAST) begin
                            state        <= DONE;
                            bus.seq_busy <= 1'b0;
                            bus.seq_done <= 1'b1;
                        end else begin
                            k     <= k + 1'b1;
                            state <= RELEASE;
                        end
                    end else if (ack_cnt == 16'd1) begin
                        state           <= ERROR;
                        bus.seq_busy    <= 1'b0;
                        bus.timeout_err <= 1'b1;
                        bus.err_stage   <= k;
                    end else begin
                        ack_cnt <= ack_cnt - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hs_unit_reset_sequencer.sv
// tb_hs_unit_reset_sequencer: directed checks of release order, latency, timeout,
// soft restart and mid-sequence reset on two parameterisations.
module tb_hs_unit_reset_sequencer;
    logic clk = 1'b0;
    logic ra, rb;
    int   cyc, n_tests, n_fail;
    always #5 clk = ~clk;
    hs_unit_reset_sequencer_if #(.NUM_STAGES(4)) ia ();
    hs_unit_reset_sequencer_if #(.NUM_STAGES(4)) ib ();
    hs_unit_reset_sequencer dut_a (.clk(clk), .resetn(ra), .bus(ia));
    hs_unit_reset_sequencer #(.ACK_TIMEOUT(8)) dut_b (.clk(clk), .resetn(rb), .bus(ib));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask
    task automatic check_reset_a(input string tag);
        check({tag, "_sr"}, ia.stage_resetn, 4'b0000);
        check({tag, "_busy"}, ia.seq_busy, 1'b1);
        check({tag, "_done"}, ia.seq_done, 1'b0);
        check({tag, "_terr"}, ia.timeout_err, 1'b0);
        check({tag, "_estage"}, ia.err_stage, 2'd0);
    endtask
    // Released stages must always form a contiguous run from stage 0 upward.
    always @(negedge clk) begin
        check("order_a", 32'(ia.stage_resetn & (ia.stage_resetn + 4'd1)), 0);
        check("order_b", 32'(ib.stage_resetn & (ib.stage_resetn + 4'd1)), 0);
    end
    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        ra = 1'b0; rb = 1'b0;
        ia.soft_req = 1'b0; ia.stage_ack = 4'b1111;
        ib.soft_req = 1'b0; ib.stage_ack = 4'b1101;
        step(2);
        check_reset_a("rst");
        ra = 1'b1; cyc = 0;
        step(17); check("hold_end", ia.stage_resetn, 4'b0000);
        step(1);  check("rel0", ia.stage_resetn, 4'b0001);
        step(2);  check("rel1", ia.stage_resetn, 4'b0011);
        step(2);  check("rel2", ia.stage_resetn, 4'b0111);
        step(2);  check("rel3", ia.stage_resetn, 4'b1111);
        check("pre_done", ia.seq_done, 1'b0);
        check("pre_busy", ia.seq_busy, 1'b1);
        step(1);  check("done25", ia.seq_done, 1'b1);
        check("idle_busy", ia.seq_busy, 1'b0);
        ia.soft_req = 1'b1; step(1); ia.soft_req = 1'b0; cyc = 0;
        check("soft_sr", ia.stage_resetn, 4'b0000);
        check("soft_busy", ia.seq_busy, 1'b1);
        check("soft_done", ia.seq_done, 1'b0);
        step(18); check("soft_rel0", ia.stage_resetn, 4'b0001);
        step(6);  check("soft_pre_done", ia.seq_done, 1'b0);
        check("soft_rel3", ia.stage_resetn, 4'b1111);
        step(1);  check("soft_done25", ia.seq_done, 1'b1);
        ra = 1'b0; ia.stage_ack = 4'b1011; step(2); ra = 1'b1; cyc = 0;
        step(22); check("slow_rel2", ia.stage_resetn, 4'b0111);
        step(9);  check("slow_wait", ia.stage_resetn, 4'b0111);
        ia.stage_ack = 4'b1111;
        step(1);  check("slow_rel_pend", ia.stage_resetn, 4'b0111);
        step(1);  check("slow_rel3", ia.stage_resetn, 4'b1111);
        step(1);  check("slow_done", ia.seq_done, 1'b1);
        check("slow_terr", ia.timeout_err, 1'b0);
        ra = 1'b0; ia.stage_ack = 4'b1011; step(2); ra = 1'b1; cyc = 0;
        step(25); check("mid_wait_k2", ia.stage_resetn, 4'b0111);
        ra = 1'b0; step(1); ra = 1'b1;
        check_reset_a("midrst");
        ia.stage_ack = 4'b1111; cyc = 0;
        step(24); check("midrst_pre", ia.seq_done, 1'b0);
        step(1);  check("midrst_done", ia.seq_done, 1'b1);
        ra = 1'b0;
        rb = 1'b1; cyc = 0;
        step(20); check("to_rel1", ib.stage_resetn, 4'b0011);
        step(7);  check("to_pre_terr", ib.timeout_err, 1'b0);
        check("to_pre_busy", ib.seq_busy, 1'b1);
        step(1);  check("to_terr", ib.timeout_err, 1'b1);
        check("to_estage", ib.err_stage, 2'd1);
        check("to_sr", ib.stage_resetn, 4'b0011);
        check("to_busy", ib.seq_busy, 1'b0);
        check("to_done", ib.seq_done, 1'b0);
        step(5);  check("to_sticky", ib.timeout_err, 1'b1);
        check("to_sr_keep", ib.stage_resetn, 4'b0011);
        ib.soft_req = 1'b1; step(1); ib.soft_req = 1'b0;
        check("err_clr_terr", ib.timeout_err, 1'b0);
        check("err_clr_estage", ib.err_stage, 2'd0);
        check("err_clr_sr", ib.stage_resetn, 4'b0000);
        check("err_clr_busy", ib.seq_busy, 1'b1);
        ib.stage_ack = 4'b1111; cyc = 0;
        step(25); check("err_rerun_done", ib.seq_done, 1'b1);
        check("err_rerun_terr", ib.timeout_err, 1'b0);
        ib.soft_req = 1'b1; step(5);
        check("held_sr", ib.stage_resetn, 4'b0000);
        check("held_busy", ib.seq_busy, 1'b1);
        ib.soft_req = 1'b0; cyc = 0;
        step(17); check("held_hold_end", ib.stage_resetn, 4'b0000);
        step(7);  check("held_pre_done", ib.seq_done, 1'b0);
        step(1);  check("held_done", ib.seq_done, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hs_unit_reset_sequencer.md
HS_UNIT_RESET_SEQUENCER -- requirements
Module: hs_unit_reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4, SHALL set the number of sequenced reset domains (legal range 1..8).
REQ-002 Parameter HOLD_CYCLES, default 16, SHALL set the cycles all stage resets are held asserted before any release (legal range 1..65535).
REQ-003 Parameter ACK_TIMEOUT, default 256, SHALL set the maximum cycles to wait for a stage acknowledge (legal range 1..65535).
REQ-004 Port clk, input, 1, SHALL be the single clock; all logic is rising-edge clk.
REQ-005 Port resetn, input, 1, SHALL be the reset: synchronous, active-low.
REQ-006 Port soft_req, input, 1, SHALL be a level request to re-run the full sequence, sampled each clk.
REQ-007 Port stage_ack, input, NUM_STAGES, SHALL carry per-stage "domain out of reset" acknowledges, active-high, treated as synchronous to clk.
REQ-008 Port stage_resetn, output, NUM_STAGES, SHALL carry per-domain active-low resets, registered.
REQ-009 Port seq_busy, output, 1, SHALL be high while a sequence is in progress.
REQ-010 Port seq_done, output, 1, SHALL be high when all stages are released and acknowledged.
REQ-011 Port timeout_err, output, 1, SHALL be a sticky error flag for an acknowledge timeout.
REQ-012 Port err_stage, output, max(1,$clog2(NUM_STAGES)), SHALL hold the index of the stage that timed out.

Function
REQ-013 The FSM SHALL have the states HOLD, RELEASE, WAIT_ACK, DONE and ERROR.
REQ-014 HOLD SHALL drive stage_resetn all-0 and seq_busy=1, and SHALL count HOLD_CYCLES cycles with a 16-bit down-counter; on expiry it SHALL go to RELEASE with stage index k=0.
REQ-015 RELEASE SHALL last exactly one cycle: set stage_resetn[k]=1 (registered; visible the next cycle), load the timeout counter with ACK_TIMEOUT, and go to WAIT_ACK.
REQ-016 WAIT_ACK SHALL sample stage_ack[k] each cycle. If 1 and k<NUM_STAGES-1: k<=k+1 and go to RELEASE. If 1 and k=NUM_STAGES-1: go to DONE.
REQ-017 In WAIT_ACK, if stage_ack[k]=0 for ACK_TIMEOUT consecutive cycles, the FSM SHALL go to ERROR, set timeout_err=1, and load err_stage=k.
REQ-018 Released stages SHALL remain released in WAIT_ACK, DONE and ERROR; stages above k SHALL remain asserted.
REQ-019 DONE SHALL drive seq_done=1 and seq_busy=0; ERROR SHALL drive seq_busy=0 and seq_done=0.
REQ-020 soft_req=1 in any state SHALL force HOLD on the next cycle, with all stage_resetn=0, the hold counter reloaded, k=0 and seq_done=0; a held-high soft_req SHALL keep the FSM in HOLD with the counter reloaded each cycle.
REQ-021 timeout_err and err_stage SHALL clear only on a soft_req-initiated HOLD entry or on resetn.
REQ-022 stage_ack bits for stages other than k SHALL be ignored; an ack already high on entry to WAIT_ACK SHALL complete that stage in one cycle.
REQ-023 The sequence SHALL be strictly ordered: at no cycle SHALL stage_resetn[j]=1 while stage_resetn[i]=0 for i<j.
REQ-024 Minimum latency from resetn deassertion to seq_done=1 SHALL be HOLD_CYCLES + 2*NUM_STAGES + 1 cycles when all acks are tied high.

Reset
REQ-025 While resetn=0 at a clk edge, the block SHALL set state=HOLD, the hold counter=HOLD_CYCLES, k=0, stage_resetn=0, seq_busy=1, seq_done=0, timeout_err=0, and err_stage=0.
REQ-026 resetn assertion mid-sequence (any state) SHALL take priority over soft_req and all acks, and SHALL assert all stage resets at the same edge.

Verification
REQ-027 NUM_STAGES=4, HOLD_CYCLES=16, acks tied 1, resetn released at cycle 0 -> stage_resetn goes 0001, 0011, 0111, 1111 at spaced cycles; seq_done=1 at cycle 25.
REQ-028 stage_ack[2] delayed 10 cycles after stage_resetn[2] rises -> stage_resetn[3] rises 11 cycles later; seq_done follows; no timeout_err.
REQ-029 ACK_TIMEOUT=8, stage_ack[1] held 0 -> after 8 cycles in WAIT_ACK: timeout_err=1, err_stage=1, stage_resetn=0011, seq_busy=0.
REQ-030 1-cycle soft_req pulse in DONE -> next cycle stage_resetn=0000, seq_busy=1, seq_done=0; the full sequence repeats with identical timing.
REQ-031 soft_req in ERROR -> timeout_err and err_stage clear on HOLD entry; the sequence completes once acks are present.
REQ-032 resetn=0 for 1 cycle while in WAIT_ACK at k=2 -> next cycle all outputs equal REQ-025 values; the sequence restarts from HOLD.
